// File: rtl/mem_pkg.sv
// Shared types and memory-op encodings for the mem_arb memory-port arbiter.
package mem_pkg;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LH  = 3'b001;
   localparam logic [2:0] OP_LW  = 3'b010;
   localparam logic [2:0] OP_LBU = 3'b100;
   localparam logic [2:0] OP_LHU = 3'b101;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT     = 2'd2,
      RESP_ERR = 2'd3
   } state_t;

   typedef enum logic {
      OWN_IFU = 1'b0,
      OWN_LSU = 1'b1
   } owner_t;

   function automatic logic op_legal(input logic [2:0] op);
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
         default:                             return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-input round-robin grant; last_grant only advances when a grant is accepted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   logic last_grant;  // 1 = requester 1 won most recently

   always_comb begin
      gnt = req;
      if (req[0] && req[1]) begin
         gnt = last_grant ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
      end else if (en) begin
         last_grant <= gnt[1];
      end
   end

endmodule

// File: rtl/mem_arb.sv
// IFU/LSU arbiter and sequencer for the single memory port: one transaction in flight at a time.
module mem_arb
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_rsp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   output logic              ifu_err,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic              lsu_we,
   input  logic [2:0]        lsu_op,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_rsp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              lsu_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [2:0]        mem_op,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nx;
   owner_t     owner_q, grant_owner, rsp_owner;
   logic [1:0] gnt;
   logic       accept, rsp_fire, rsp_err, cnt_clr, cnt_inc;
   logic [7:0] cnt;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({lsu_req_valid, ifu_req_valid}),
      .en  (accept),
      .gnt (gnt)
   );

   assign grant_owner = gnt[1] ? OWN_LSU : OWN_IFU;
   // An illegal op is answered in the accept cycle, before owner_q is loaded.
   assign rsp_owner   = (state == IDLE) ? grant_owner : owner_q;
   assign busy        = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      rsp_fire      = 1'b0;
      rsp_err       = 1'b0;
      cnt_clr       = 1'b0;
      cnt_inc       = 1'b0;
      mem_req_valid = 1'b0;
      ifu_req_ready = 1'b0;
      lsu_req_ready = 1'b0;
      case (state)
         IDLE: begin
            ifu_req_ready = gnt[0];
            lsu_req_ready = gnt[1];
            if (|gnt) begin
               accept = 1'b1;
               if (gnt[1] && !op_legal(lsu_op)) begin
                  state_nx = RESP_ERR;
                  rsp_fire = 1'b1;
                  rsp_err  = 1'b1;
               end else begin
                  state_nx = ISSUE;
               end
            end
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               state_nx = WAIT;
               cnt_clr  = 1'b1;
            end
         end
         WAIT: begin
            cnt_inc = 1'b1;
            if (mem_rsp_valid) begin
               state_nx = IDLE;
               rsp_fire = 1'b1;
            end else if (cnt == TO_LAST) begin
               state_nx = IDLE;
               rsp_fire = 1'b1;
               rsp_err  = 1'b1;
            end
         end
         RESP_ERR: state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else if (cnt_inc) begin
         cnt <= cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_op    <= OP_LW;
         mem_wdata <= '0;
         owner_q   <= OWN_IFU;
      end else if (accept) begin
         mem_addr  <= gnt[1] ? lsu_addr : ifu_addr;
         mem_we    <= gnt[1] & lsu_we;
         mem_op    <= gnt[1] ? lsu_op : OP_LW;
         mem_wdata <= gnt[1] ? lsu_wdata : '0;
         owner_q   <= grant_owner;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ifu_rsp_valid <= 1'b0;
         ifu_err       <= 1'b0;
         ifu_rdata     <= '0;
         lsu_rsp_valid <= 1'b0;
         lsu_err       <= 1'b0;
         lsu_rdata     <= '0;
      end else begin
         ifu_rsp_valid <= rsp_fire && (rsp_owner == OWN_IFU);
         ifu_err       <= rsp_fire && rsp_err && (rsp_owner == OWN_IFU);
         lsu_rsp_valid <= rsp_fire && (rsp_owner == OWN_LSU);
         lsu_err       <= rsp_fire && rsp_err && (rsp_owner == OWN_LSU);
         if (rsp_fire && (rsp_owner == OWN_IFU)) begin
            ifu_rdata <= rsp_err ? '0 : mem_rdata;
         end
         if (rsp_fire && (rsp_owner == OWN_LSU)) begin
            lsu_rdata <= rsp_err ? '0 : mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: directed requests push expected responses, a monitor pops and checks them.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_err;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_rsp_valid, lsu_err;
   logic [2:0]  lsu_op;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, busy;
   logic [2:0]  mem_op;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_ready (ifu_req_ready),
      .ifu_addr      (ifu_addr),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rdata     (ifu_rdata),
      .ifu_err       (ifu_err),
      .lsu_req_valid (lsu_req_valid),
      .lsu_req_ready (lsu_req_ready),
      .lsu_addr      (lsu_addr),
      .lsu_we        (lsu_we),
      .lsu_op        (lsu_op),
      .lsu_wdata     (lsu_wdata),
      .lsu_rsp_valid (lsu_rsp_valid),
      .lsu_rdata     (lsu_rdata),
      .lsu_err       (lsu_err),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_op        (mem_op),
      .mem_wdata     (mem_wdata),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rdata     (mem_rdata),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          own;      // 0 = IFU, 1 = LSU
      bit          err;
      logic [31:0] rdata;
      bit          chk_data;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   cyc = 0;
   int   acc_cnt = 0;
   int   rsp_cnt = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_req_valid && mem_req_ready) acc_cnt <= acc_cnt + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input bit own, input bit err, input logic [31:0] rd, input bit cd, input int c);
      exp_t e;
      e.own = own; e.err = err; e.rdata = rd; e.chk_data = cd; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic score(input bit own, input logic err, input logic [31:0] rd);
      exp_t e;
      rsp_cnt++;
      if (sb.size() == 0) begin
         total++;
         $display("FAIL rsp_unexpected: got response for owner %0d, expected none (cycle %0d)", own, cyc);
         return;
      end
      e = sb.pop_front();
      chk("rsp_owner", 32'(own), 32'(e.own));
      chk("rsp_err", 32'(err), 32'(e.err));
      if (e.chk_data) chk("rsp_rdata", rd, e.rdata);
      chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
   endtask

   always @(negedge clk) begin
      if (ifu_rsp_valid) score(1'b0, ifu_err, ifu_rdata);
      if (lsu_rsp_valid) score(1'b1, lsu_err, lsu_rdata);
   end

   // Memory side: accepts after `stall` low-ready cycles, then optionally answers in the first WAIT cycle.
   task automatic serve(input int stall, input logic [31:0] rd, input bit respond);
      int          n;
      int          bad;
      logic [31:0] a, wd;
      logic        w;
      logic [2:0]  o;
      n = 0;
      while (!mem_req_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("serve_req_seen", 32'(mem_req_valid), 32'h1);
      a = mem_addr; wd = mem_wdata; w = mem_we; o = mem_op;
      bad = 0;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         if (!mem_req_valid || mem_addr !== a || mem_wdata !== wd || mem_we !== w || mem_op !== o) bad++;
      end
      if (stall > 0) chk("serve_stable", 32'(bad), 32'h0);
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("serve_valid_low_in_wait", 32'(mem_req_valid), 32'h0);
      if (respond) begin
         mem_rsp_valid = 1'b1;
         mem_rdata     = rd;
         @(negedge clk);
         mem_rsp_valid = 1'b0;
         mem_rdata     = '0;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int          t0;
      int          acc0;
      int          rsp0;
      bit          exp_ifu;
      logic [31:0] ia, la;

      rst = 1'b1;
      ifu_req_valid = 1'b0; ifu_addr = '0;
      lsu_req_valid = 1'b0; lsu_addr = '0; lsu_we = 1'b0; lsu_op = 3'b010; lsu_wdata = '0;
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'h0);
      chk("rst_mem_op", 32'(mem_op), 32'h2);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'h0);
      chk("rst_lsu_err", 32'(lsu_err), 32'h0);
      chk("rst_ifu_rdata", ifu_rdata, 32'h0);
      rst = 1'b0;

      // Single IFU fetch, minimum latency
      @(negedge clk);
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; #1;
      chk("fetch_ifu_ready", 32'(ifu_req_ready), 32'h1);
      chk("fetch_lsu_ready", 32'(lsu_req_ready), 32'h0);
      push(1'b0, 1'b0, 32'h0000_0413, 1'b1, cyc + 3);
      @(negedge clk);
      ifu_req_valid = 1'b0;
      chk("fetch_mem_valid", 32'(mem_req_valid), 32'h1);
      chk("fetch_mem_op", 32'(mem_op), 32'h2);
      chk("fetch_mem_we", 32'(mem_we), 32'h0);
      chk("fetch_mem_addr", mem_addr, 32'h8000_0000);
      chk("fetch_busy", 32'(busy), 32'h1);
      serve(0, 32'h0000_0413, 1'b1);
      @(negedge clk);

      // Contention from reset: IFU, LSU, IFU, LSU
      rst = 1'b1;
      ia = 32'h8000_0100; la = 32'h8000_2000;
      ifu_req_valid = 1'b1; ifu_addr = ia;
      lsu_req_valid = 1'b1; lsu_addr = la; lsu_op = 3'b100; lsu_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_ifu = (k % 2 == 0);
         chk("cont_ifu_ready", 32'(ifu_req_ready), 32'(exp_ifu));
         chk("cont_lsu_ready", 32'(lsu_req_ready), 32'(!exp_ifu));
         push(!exp_ifu, 1'b0, 32'h0000_1000 + 32'(k), 1'b1, cyc + 3);
         @(negedge clk);
         chk("cont_mem_addr", mem_addr, exp_ifu ? ia : la);
         chk("cont_mem_op", 32'(mem_op), exp_ifu ? 32'h2 : 32'h4);
         chk("cont_no_ready_busy", 32'({ifu_req_ready, lsu_req_ready}), 32'h0);
         serve(0, 32'h0000_1000 + 32'(k), 1'b1);
      end
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      @(negedge clk);

      // Store with 3 cycles of backpressure
      lsu_req_valid = 1'b1; lsu_we = 1'b1; lsu_op = 3'b000;
      lsu_addr = 32'h8000_1003; lsu_wdata = 32'h0000_00AB; #1;
      chk("store_lsu_ready", 32'(lsu_req_ready), 32'h1);
      acc0 = acc_cnt;
      push(1'b1, 1'b0, 32'h0, 1'b0, cyc + 6);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      chk("store_mem_we", 32'(mem_we), 32'h1);
      chk("store_mem_op", 32'(mem_op), 32'h0);
      chk("store_mem_wdata", mem_wdata, 32'h0000_00AB);
      chk("store_mem_addr", mem_addr, 32'h8000_1003);
      serve(3, 32'hDEAD_BEEF, 1'b1);
      chk("store_accepts", 32'(acc_cnt - acc0), 32'h1);
      @(negedge clk);

      // Illegal op 011
      lsu_req_valid = 1'b1; lsu_we = 1'b0; lsu_op = 3'b011; lsu_addr = 32'h8000_0040; #1;
      chk("illegal_lsu_ready", 32'(lsu_req_ready), 32'h1);
      acc0 = acc_cnt;
      push(1'b1, 1'b1, 32'h0, 1'b1, cyc + 1);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      chk("illegal_no_mem_valid", 32'(mem_req_valid), 32'h0);
      chk("illegal_busy", 32'(busy), 32'h1);
      @(negedge clk);
      chk("illegal_idle", 32'(busy), 32'h0);
      chk("illegal_no_accept", 32'(acc_cnt - acc0), 32'h0);
      @(negedge clk);

      // Timeout (TIMEOUT=4): WAIT entered at T+2, error pulse at T+6
      lsu_req_valid = 1'b1; lsu_op = 3'b010; lsu_addr = 32'h8000_0080; #1;
      chk("to_lsu_ready", 32'(lsu_req_ready), 32'h1);
      t0 = cyc;
      push(1'b1, 1'b1, 32'h0, 1'b1, t0 + 6);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      serve(0, 32'h0, 1'b0);
      while (cyc < t0 + 6) @(negedge clk);
      chk("to_idle", 32'(busy), 32'h0);
      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0200; #1;
      chk("to_ready_after", 32'(ifu_req_ready), 32'h1);
      @(negedge clk);
      ifu_req_valid = 1'b0;

      // Reset in the middle of WAIT
      serve(0, 32'h0, 1'b0);
      chk("rw_in_wait", 32'(busy), 32'h1);
      rsp0 = rsp_cnt;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rw_busy_cleared", 32'(busy), 32'h0);
      repeat (3) @(negedge clk);
      chk("rw_no_rsp", 32'(rsp_cnt - rsp0), 32'h0);

      ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0300;
      lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_op = 3'b010; #1;
      chk("rw_ifu_wins", 32'(ifu_req_ready), 32'h1);
      chk("rw_lsu_waits", 32'(lsu_req_ready), 32'h0);
      push(1'b0, 1'b0, 32'hCAFE_0001, 1'b1, cyc + 3);
      @(negedge clk);
      ifu_req_valid = 1'b0;
      serve(0, 32'hCAFE_0001, 1'b1);
      #1;
      chk("rw_lsu_next", 32'(lsu_req_ready), 32'h1);
      push(1'b1, 1'b0, 32'hBEEF_0002, 1'b1, cyc + 3);
      @(negedge clk);
      lsu_req_valid = 1'b0;
      serve(0, 32'hBEEF_0002, 1'b1);
      repeat (2) @(negedge clk);
      chk("sb_drained", 32'(sb.size()), 32'h0);
      chk("ifu_rdata_held", ifu_rdata, 32'hCAFE_0001);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
